// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory-busy freezes.
// Control outputs are combinational; state, bubble counter, pending flush and event counters are registered.
//
// state    | meaning
// RUN      | normal issue; detects load-use and branch events
// LU_STALL | inserting the remaining load-use bubbles (luCntQ left)
// MEM_WAIT | whole pipeline frozen while data memory is busy
module hazard_stall_unit #(
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_RegRs1,
  input  logic [4:0]  IF_ID_RegRs2,
  input  logic        IF_ID_UsesRs1,
  input  logic        IF_ID_UsesRs2,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegRd,
  input  logic        EX_Branch_Taken,
  input  logic        Mem_Busy,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic [1:0]  State,
  output logic [15:0] Stall_Count,
  output logic [15:0] Freeze_Count,
  output logic [15:0] Flush_Count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

  state_t      stateQ, stateD;
  logic        flushPendingQ, flushPendingD;
  logic [1:0]  luCntQ, luCntD;
  logic [15:0] stallCntQ, freezeCntQ, flushCntQ;
  logic        incStall, incFreeze, incFlush;
  logic        luHazard, branchReq, bubbleOwed;

  assign luHazard = ID_EX_MemRead && (ID_EX_RegRd != 5'd0) &&
                    ((IF_ID_UsesRs1 && (ID_EX_RegRd == IF_ID_RegRs1)) ||
                     (IF_ID_UsesRs2 && (ID_EX_RegRd == IF_ID_RegRs2)));

  assign branchReq = EX_Branch_Taken || flushPendingQ;

  // Bubbles left over from an interrupted load-use stall resume after a freeze.
  assign bubbleOwed = (stateQ == LU_STALL) || ((stateQ == MEM_WAIT) && (luCntQ != 2'd0));

  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    stateD        = stateQ;
    flushPendingD = flushPendingQ;
    luCntD        = luCntQ;
    incStall      = 1'b0;
    incFreeze     = 1'b0;
    incFlush      = 1'b0;

    if (reset) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (Mem_Busy) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      stateD       = MEM_WAIT;
      incFreeze    = 1'b1;
      // A branch resolving as the freeze begins is remembered and flushed afterwards.
      if (stateQ != MEM_WAIT && EX_Branch_Taken) begin
        flushPendingD = 1'b1;
      end
    end else if (branchReq) begin
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      flushPendingD = 1'b0;
      luCntD        = 2'd0;
      stateD        = RUN;
      incFlush      = 1'b1;
    end else if (bubbleOwed) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      incStall    = 1'b1;
      luCntD      = luCntQ - 2'd1;
      stateD      = (luCntQ == 2'd1) ? RUN : LU_STALL;
    end else if (luHazard) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      incStall    = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        luCntD = LU_RELOAD;
        stateD = LU_STALL;
      end else begin
        stateD = RUN;
      end
    end else begin
      stateD = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ        <= RUN;
      flushPendingQ <= 1'b0;
      luCntQ        <= 2'd0;
      stallCntQ     <= 16'd0;
      freezeCntQ    <= 16'd0;
      flushCntQ     <= 16'd0;
    end else begin
      stateQ        <= stateD;
      flushPendingQ <= flushPendingD;
      luCntQ        <= luCntD;
      if (incStall && stallCntQ != 16'hFFFF) begin
        stallCntQ <= stallCntQ + 16'd1;
      end
      if (incFreeze && freezeCntQ != 16'hFFFF) begin
        freezeCntQ <= freezeCntQ + 16'd1;
      end
      if (incFlush && flushCntQ != 16'hFFFF) begin
        flushCntQ <= flushCntQ + 16'd1;
      end
    end
  end

  assign State        = stateQ;
  assign Stall_Count  = stallCntQ;
  assign Freeze_Count = freezeCntQ;
  assign Flush_Count  = flushCntQ;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed table, hand sequences, random vs. model, saturation.
// Two instances run side by side: default bubble count (1) and three bubbles.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, u1, u2, mr, br, busy;
  logic [4:0] rs1, rs2, rd;

  logic        pcW0, ifidW0, idexW0, exmW0, ifidF0, idexF0;
  logic        pcW1, ifidW1, idexW1, exmW1, ifidF1, idexF1;
  logic [1:0]  st0, st1;
  logic [15:0] stall0, freeze0, flush0, stall1, freeze1, flush1;

  hazard_stall_unit #(.LU_STALL_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset),
    .IF_ID_RegRs1(rs1), .IF_ID_RegRs2(rs2), .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
    .ID_EX_MemRead(mr), .ID_EX_RegRd(rd), .EX_Branch_Taken(br), .Mem_Busy(busy),
    .PC_Write(pcW0), .IF_ID_Write(ifidW0), .ID_EX_Write(idexW0), .EX_MEM_Write(exmW0),
    .IF_ID_Flush(ifidF0), .ID_EX_Flush(idexF0), .State(st0),
    .Stall_Count(stall0), .Freeze_Count(freeze0), .Flush_Count(flush0)
  );

  hazard_stall_unit #(.LU_STALL_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset),
    .IF_ID_RegRs1(rs1), .IF_ID_RegRs2(rs2), .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
    .ID_EX_MemRead(mr), .ID_EX_RegRd(rd), .EX_Branch_Taken(br), .Mem_Busy(busy),
    .PC_Write(pcW1), .IF_ID_Write(ifidW1), .ID_EX_Write(idexW1), .EX_MEM_Write(exmW1),
    .IF_ID_Flush(ifidF1), .ID_EX_Flush(idexF1), .State(st1),
    .Stall_Count(stall1), .Freeze_Count(freeze1), .Flush_Count(flush1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ctl packing: {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush}
  function automatic int ctlOf(int d);
    if (d == 0) return int'({pcW0, ifidW0, idexW0, exmW0, ifidF0, idexF0});
    return int'({pcW1, ifidW1, idexW1, exmW1, ifidF1, idexF1});
  endfunction
  function automatic int stOf(int d);     return (d == 0) ? int'(st0) : int'(st1); endfunction
  function automatic int stallOf(int d);  return (d == 0) ? int'(stall0) : int'(stall1); endfunction
  function automatic int freezeOf(int d); return (d == 0) ? int'(freeze0) : int'(freeze1); endfunction
  function automatic int flushOf(int d);  return (d == 0) ? int'(flush0) : int'(flush1); endfunction

  task automatic drive(bit r, int a1, int a2, int d, bit e1, bit e2, bit m, bit b, bit bz);
    reset = r; rs1 = 5'(a1); rs2 = 5'(a2); rd = 5'(d);
    u1 = e1; u2 = e2; mr = m; br = b; busy = bz;
  endtask

  // Reference model: bubbles still owed, frozen flag, remembered branch, plain event tallies.
  int bubbles[2], pending[2], frozen[2], nStall[2], nFreeze[2], nFlush[2];
  int bubblesPerLoad[2] = '{1, 3};

  function automatic bit loadUse();
    return mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction

  function automatic int modelCtl(int d);
    if (reset) return 'b111111;
    if (busy) return 'b000000;
    if (br || pending[d] != 0) return 'b111111;
    if (bubbles[d] > 0 || loadUse()) return 'b001101;
    return 'b111100;
  endfunction

  function automatic int modelState(int d);
    if (frozen[d] != 0) return 2;
    if (bubbles[d] > 0) return 1;
    return 0;
  endfunction

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic modelStep(int d);
    if (reset) begin
      bubbles[d] = 0; pending[d] = 0; frozen[d] = 0;
      nStall[d] = 0; nFreeze[d] = 0; nFlush[d] = 0;
    end else if (busy) begin
      if (br && frozen[d] == 0) pending[d] = 1;
      frozen[d] = 1;
      nFreeze[d] = sat(nFreeze[d]);
    end else begin
      frozen[d] = 0;
      if (br || pending[d] != 0) begin
        pending[d] = 0; bubbles[d] = 0;
        nFlush[d] = sat(nFlush[d]);
      end else if (bubbles[d] > 0 || loadUse()) begin
        nStall[d] = sat(nStall[d]);
        bubbles[d] = (bubbles[d] > 0) ? bubbles[d] - 1 : bubblesPerLoad[d] - 1;
      end
    end
  endtask

  task automatic modelCycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rnd ctl dut%0d", d), ctlOf(d), modelCtl(d));
      modelStep(d);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rnd state dut%0d", d), stOf(d), modelState(d));
      check($sformatf("rnd stall dut%0d", d), stallOf(d), nStall[d]);
      check($sformatf("rnd freeze dut%0d", d), freezeOf(d), nFreeze[d]);
      check($sformatf("rnd flush dut%0d", d), flushOf(d), nFlush[d]);
    end
  endtask

  // Hand-sequence step on the three-bubble instance: ctl and pre-edge state, then post-edge state.
  task automatic step1(string name, int expCtl, int expStBefore, int expStAfter);
    @(negedge clk);
    check({name, " ctl"}, ctlOf(1), expCtl);
    check({name, " state before"}, stOf(1), expStBefore);
    @(posedge clk); #1;
    check({name, " state after"}, stOf(1), expStAfter);
  endtask

  typedef struct {
    bit rst; int a1, a2, d; bit e1, e2, m, b, bz;
    int ctl, st, stall, freeze, flush;
  } vec_t;

  function automatic vec_t mk(bit r, int a1, int a2, int d, bit e1, bit e2, bit m, bit b, bit bz,
                              int ctl, int st, int s, int f, int fl);
    vec_t v;
    v.rst = r; v.a1 = a1; v.a2 = a2; v.d = d; v.e1 = e1; v.e2 = e2; v.m = m; v.b = b; v.bz = bz;
    v.ctl = ctl; v.st = st; v.stall = s; v.freeze = f; v.flush = fl;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 'b111111, 0, 0, 0, 0);
    tbl[1]  = mk(0, 5, 0, 5, 1, 0, 1, 0, 0, 'b001101, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b111100, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 'b111100, 0, 1, 0, 0);
    tbl[4]  = mk(0, 3, 7, 7, 1, 0, 1, 0, 0, 'b111100, 0, 1, 0, 0);
    tbl[5]  = mk(0, 3, 7, 7, 1, 1, 1, 0, 0, 'b001101, 0, 2, 0, 0);
    tbl[6]  = mk(0, 7, 0, 7, 1, 0, 0, 0, 0, 'b111100, 0, 2, 0, 0);
    tbl[7]  = mk(0, 5, 0, 5, 1, 0, 1, 1, 0, 'b111111, 0, 2, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'b000000, 2, 2, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000000, 2, 2, 2, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000000, 2, 2, 3, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000000, 2, 2, 4, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b111111, 0, 2, 4, 2);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b111100, 0, 2, 4, 2);
    tbl[14] = mk(1, 5, 0, 5, 1, 0, 1, 0, 1, 'b111111, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Directed table on the single-bubble instance.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].a1, tbl[i].a2, tbl[i].d, tbl[i].e1, tbl[i].e2,
            tbl[i].m, tbl[i].b, tbl[i].bz);
      @(negedge clk);
      check($sformatf("tbl%0d ctl", i), ctlOf(0), tbl[i].ctl);
      @(posedge clk); #1;
      check($sformatf("tbl%0d state", i), stOf(0), tbl[i].st);
      check($sformatf("tbl%0d stall", i), stallOf(0), tbl[i].stall);
      check($sformatf("tbl%0d freeze", i), freezeOf(0), tbl[i].freeze);
      check($sformatf("tbl%0d flush", i), flushOf(0), tbl[i].flush);
    end

    // Three-bubble load-use: states 00,01,01 then RUN, three stalls.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step1("p3 reset", 'b111111, 0, 0);
    drive(0, 5, 0, 5, 1, 0, 1, 0, 0);
    step1("p3 lu1", 'b001101, 0, 1);
    step1("p3 lu2", 'b001101, 1, 1);
    step1("p3 lu3", 'b001101, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step1("p3 done", 'b111100, 0, 0);
    check("p3 stall count", stallOf(1), 3);

    // Freeze in the middle of the bubbles: remaining bubbles resume afterwards.
    drive(0, 5, 0, 5, 1, 0, 1, 0, 0);
    step1("p3 lu again", 'b001101, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step1("p3 freeze", 'b000000, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step1("p3 resume1", 'b001101, 2, 1);
    step1("p3 resume2", 'b001101, 1, 0);
    step1("p3 idle", 'b111100, 0, 0);
    check("p3 stall after resume", stallOf(1), 6);
    check("p3 freeze after resume", freezeOf(1), 1);

    // Reset while in LU_STALL clears everything.
    drive(0, 5, 0, 5, 1, 0, 1, 0, 0);
    step1("p3 lu pre-reset", 'b001101, 0, 1);
    drive(1, 5, 0, 5, 1, 0, 1, 0, 0);
    step1("p3 reset mid-stall", 'b111111, 1, 0);
    check("p3 stall after reset", stallOf(1), 0);
    check("p3 freeze after reset", freezeOf(1), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step1("p3 no leftover bubble", 'b111100, 0, 0);

    // Random traffic against the model on both instances.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    modelCycle();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      modelCycle();
    end

    // Freeze counter saturation.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (65534) @(posedge clk);
    #1;
    check("freeze near max", freezeOf(0), 'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("freeze saturated", freezeOf(0), 'hFFFF);
    check("freeze saturated state", stOf(0), 2);
    check("freeze saturated dut1", freezeOf(1), 'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, legal range 1..3: number of bubbles inserted for a load-use hazard.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports IF_ID_RegRs1 and IF_ID_RegRs2, input, 5 each, source register numbers of the instruction in ID.
REQ-005 SHALL have ports IF_ID_UsesRs1 and IF_ID_UsesRs2, input, 1 each, high when the ID instruction reads that source.
REQ-006 SHALL have port ID_EX_MemRead, input, 1, high when the EX-stage instruction is a load.
REQ-007 SHALL have port ID_EX_RegRd, input, 5, destination register number of the EX-stage instruction.
REQ-008 SHALL have port EX_Branch_Taken, input, 1, high when a branch or jump resolved in EX redirects the PC.
REQ-009 SHALL have port Mem_Busy, input, 1, high when data memory cannot complete its access this cycle.
REQ-010 SHALL have ports PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write, output, 1 each, pipeline register enables.
REQ-011 SHALL have ports IF_ID_Flush and ID_EX_Flush, output, 1 each, which replace that register's contents with a NOP.
REQ-012 SHALL have port State, output, 2, current FSM state: RUN=00, LU_STALL=01, MEM_WAIT=10.
REQ-013 SHALL have ports Stall_Count, Freeze_Count and Flush_Count, output, 16 each, saturating event counters.

Function
REQ-014 SHALL drive all control outputs combinationally from the current state, pending flag, lu_cnt and inputs; State, counters, pending flag and lu_cnt SHALL be registered.
REQ-015 Definition: load-use hazard LU = ID_EX_MemRead and ID_EX_RegRd != 0, AND (IF_ID_UsesRs1 and Rd == Rs1, OR IF_ID_UsesRs2 and Rd == Rs2).
REQ-016 Default outputs: all four Write = 1; both Flush = 0.
REQ-017 Priority in every state: Mem_Busy, then branch, then LU.
REQ-018 In any state, Mem_Busy=1 SHALL drive all four Write signals to 0 and both Flush signals to 0. Next state SHALL be MEM_WAIT. Freeze_Count SHALL increment.
REQ-019 RUN, on Mem_Busy=1 and EX_Branch_Taken=1: SHALL set flush_pending.
REQ-020 RUN, on branch (EX_Branch_Taken or flush_pending, Mem_Busy=0): IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. Clear flush_pending and lu_cnt; Flush_Count+1; next RUN. LU is ignored that cycle.
REQ-021 RUN, on LU without branch or Mem_Busy: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; Stall_Count+1.
REQ-022 Following the LU of REQ-021: if LU_STALL_CYCLES>1, load lu_cnt=LU_STALL_CYCLES-1 and go to LU_STALL; otherwise stay in RUN.
REQ-023 LU_STALL, with no Mem_Busy or branch: same outputs as REQ-021; lu_cnt-1; Stall_Count+1. SHALL go to RUN when lu_cnt reaches 0, else stay in LU_STALL.
REQ-024 LU_STALL, on branch: handled per REQ-020, abandoning the remaining bubbles.
REQ-025 MEM_WAIT, on Mem_Busy=0: evaluated exactly as RUN. If lu_cnt != 0 and there is no branch, SHALL apply LU_STALL behaviour instead.
REQ-026 MEM_WAIT SHALL preserve lu_cnt and flush_pending unchanged while Mem_Busy=1.
REQ-027 Each counter SHALL saturate at 16'hFFFF; no wrap-around.

Reset
REQ-028 While reset=1: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, EX_MEM_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
REQ-029 On the first edge with reset=1: State=RUN, lu_cnt=0, flush_pending=0, all counters 0.
REQ-030 Reset SHALL override any state mid-operation, including MEM_WAIT and LU_STALL; no pending bubble or flush survives reset.

Verification
REQ-031 Load-use hazard: ID_EX_MemRead=1, Rd=5, Rs1=5, UsesRs1=1, default parameter -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Stall_Count=1; State stays 00.
REQ-032 Rd=0 with a matching Rs1, or a match with UsesRs=0 -> no stall; Stall_Count stays 0.
REQ-033 LU_STALL_CYCLES=3 load-use -> 3 consecutive stall cycles with State 00,01,01, then RUN. Stall_Count=3.
REQ-034 EX_Branch_Taken=1 together with LU -> both flushes high, PC_Write=1, no stall; Flush_Count=1.
REQ-035 Branch-during-freeze: Mem_Busy=1 for 4 cycles with EX_Branch_Taken pulsed in the first -> 4 frozen cycles, State=10, Freeze_Count=4. The cycle after Mem_Busy falls SHALL flush, giving Flush_Count=1.
REQ-036 Reset and saturation: reset asserted in LU_STALL -> State=00 and counters 0 next cycle. With Freeze_Count forced to FFFF and Mem_Busy=1, Freeze_Count SHALL stay FFFF.
